tpu_port_arbiter: RTL

// Shares the single tpuv1 register port (r_w/addr/dataIn/dataOut) between two requesters:
// req0 = host MMIO path, req1 = on-chip batch sequencer. Arbitrates round-robin per beat,

---
 rtl/tpu_port_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/tpu_port_arbiter.sv
// tpu_port_arbiter
// Shares the single tpuv1 register port between two requesters (req0 = host
// MMIO, req1 = batch sequencer). One beat is accepted per cycle, chosen
// round-robin unless a requester holds a burst lock. The accepted beat is
// registered onto the tpu port the next cycle. Read data is returned to the
// issuing requester through a tag pipe matched to the tpu read latency.
//
// Ports
//   clk, rst_n                   clock, async active-low reset
//   reqN_valid/ready             beat handshake (N = 0,1)
//   reqN_we/addr/wdata/lock      beat payload; lock keeps the grant afterwards
//   rspN_valid/data              read response, one-cycle pulse, data held
//   tpu_r_w/addr/data_in         registered drive to tpuv1
//   tpu_data_out                 tpuv1 read data, valid RD_LAT cycles after addr
module tpu_port_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 64,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    input  logic          req0_lock,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    input  logic          req1_lock,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_data,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_data,
    output logic          tpu_r_w,
    output logic [AW-1:0] tpu_addr,
    output logic [DW-1:0] tpu_data_in,
    input  logic [DW-1:0] tpu_data_out
);

    logic          rr;        // requester favoured when both are valid
    logic          locked;
    logic          owner;
    logic          gnt0, gnt1, hs, hs_id;
    logic          sel_we, sel_lock;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // Read-tag pipe: stage k is visible RD_LAT-k cycles before data is due;
    // stage RD_LAT lines up with tpu_data_out for that beat.
    logic [RD_LAT:0] vld_pipe;
    logic [RD_LAT:0] id_pipe;

    // While locked the non-owner is held off even if the owner idles.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (locked) begin
            gnt0 = req0_valid & ~owner;
            gnt1 = req1_valid &  owner;
        end else begin
            gnt0 = req0_valid & (~req1_valid | ~rr);
            gnt1 = req1_valid & (~req0_valid |  rr);
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign hs         = gnt0 | gnt1;
    assign hs_id      = gnt1;

    assign sel_we    = hs_id ? req1_we    : req0_we;
    assign sel_lock  = hs_id ? req1_lock  : req0_lock;
    assign sel_addr  = hs_id ? req1_addr  : req0_addr;
    assign sel_wdata = hs_id ? req1_wdata : req0_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr          <= 1'b0;
            locked      <= 1'b0;
            owner       <= 1'b0;
            tpu_r_w     <= 1'b0;
            tpu_addr    <= '0;
            tpu_data_in <= '0;
        end else begin
            tpu_r_w <= hs & sel_we;
            if (hs) begin
                tpu_addr <= sel_addr;
                // Data bus only moves for writes; reads leave it untouched.
                if (sel_we)
                    tpu_data_in <= sel_wdata;
                rr     <= ~hs_id;
                // Under lock only the owner can handshake, so a lock=0 beat
                // from it is always the burst's last beat.
                locked <= sel_lock;
                owner  <= hs_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[0] <= hs & ~sel_we;
            id_pipe[0]  <= hs_id;
            for (int i = 1; i <= RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
        end else begin
            rsp0_valid <= vld_pipe[RD_LAT] & ~id_pipe[RD_LAT];
            rsp1_valid <= vld_pipe[RD_LAT] &  id_pipe[RD_LAT];
            if (vld_pipe[RD_LAT] & ~id_pipe[RD_LAT])
                rsp0_data <= tpu_data_out;
            if (vld_pipe[RD_LAT] & id_pipe[RD_LAT])
                rsp1_data <= tpu_data_out;
        end
    end

endmodule
